// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// mem_access_unit_pkg
// Shared state encoding, instruction field positions and width default.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

    localparam int DEFAULT_DATA_W = 32;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// mem_timeout_ctr
// Wait-cycle counter with clear/enable; tc flags the final allowed cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = en && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
// Req/ack bridge from the multi-cycle controller to a variable-latency memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] Instruction,
    output logic [5:0]        OpCode,
    output logic [5:0]        Funct,
    output logic [DATA_W-1:0] MemData,
    output logic              Stall,
    output logic              AddrErr,
    output logic              BusErr
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] sel_addr;
    logic              req_valid;
    logic              req_bad;
    logic              ir_sel;
    logic              tc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mdr;

    assign sel_addr  = IorD ? ALUOut : PC;
    assign req_valid = (MemRead ^ MemWrite) && (sel_addr[1:0] == 2'b00);
    assign req_bad   = (MemRead || MemWrite) && !req_valid;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (state != WAIT),
        .en    (state == WAIT),
        .tc    (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE never stalls and never accepts a request, so the controller
    // advances exactly once per completed access.
    always_comb begin
        next_state = state;
        Stall      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    Stall      = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (mem_ack || tc) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ir_sel    <= 1'b0;
            ir        <= '0;
            mdr       <= '0;
            AddrErr   <= 1'b0;
            BusErr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr  <= sel_addr;
                        mem_we    <= MemWrite;
                        mem_wdata <= WriteData;
                        ir_sel    <= IRWrite;
                        mem_req   <= 1'b1;
                    end else if (req_bad) begin
                        AddrErr <= 1'b1;
                    end
                end
                WAIT: begin
                    // A late ack on the terminal cycle still completes normally.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            if (ir_sel) begin
                                ir <= mem_rdata;
                            end else begin
                                mdr <= mem_rdata;
                            end
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (tc) begin
                        BusErr  <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Instruction = ir;
    assign MemData     = mdr;
    assign OpCode      = ir[OPCODE_MSB:OPCODE_LSB];
    assign Funct       = ir[FUNCT_MSB:FUNCT_LSB];

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        MemRead, MemWrite, IorD, IRWrite;
    logic [31:0] PC, ALUOut, WriteData, mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, Instruction, MemData;
    logic [5:0]  OpCode, Funct;
    logic        Stall, AddrErr, BusErr;

    int tests_run = 0;
    int fails     = 0;

    mem_access_unit #(.DATA_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .Instruction(Instruction), .OpCode(OpCode), .Funct(Funct), .MemData(MemData),
        .Stall(Stall), .AddrErr(AddrErr), .BusErr(BusErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
        PC = 0; ALUOut = 0; WriteData = 0; mem_rdata = 0; mem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Drives one access from a negedge; ack_at is the WAIT cycle index
    // (1 = first WAIT cycle) carrying the ack, 0 means never ack.
    task automatic run_access(
        input  logic        rd, wr, iord, irw,
        input  logic [31:0] pc, alu, wd,
        input  int          ack_at,
        input  logic [31:0] rdata,
        output int          stalls,
        output logic [31:0] addr_seen,
        output logic        we_seen,
        output logic [31:0] wdata_seen,
        output logic        req_seen,
        output bit          stable,
        output logic        req_done,
        output logic        req_after
    );
        stalls = 0; stable = 1'b1;
        addr_seen = '0; we_seen = 1'b0; wdata_seen = '0; req_seen = 1'b0;
        MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
        PC = pc; ALUOut = alu; WriteData = wd;
        for (int i = 0; i < 200; i++) begin
            mem_ack   = (ack_at != 0) && (i == ack_at);
            mem_rdata = mem_ack ? rdata : 32'hBAD0BAD0;
            #1;
            if (!Stall) break;
            stalls++;
            if (i == 1) begin
                addr_seen = mem_addr; we_seen = mem_we;
                wdata_seen = mem_wdata; req_seen = mem_req;
            end else if (i > 1) begin
                if (mem_addr !== addr_seen || mem_we !== we_seen ||
                    mem_wdata !== wdata_seen || mem_req !== 1'b1)
                    stable = 1'b0;
            end
            @(negedge clk);
        end
        req_done = mem_req;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        req_after = mem_req;
        MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
        @(negedge clk);
    endtask

    int          st;
    logic [31:0] a_s, wd_s;
    logic        we_s, rq_s, rq_d, rq_a;
    bit          stab;

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({mem_req, mem_we, Stall, AddrErr, BusErr} !== 5'b0 ||
            mem_addr !== 0 || mem_wdata !== 0 || Instruction !== 0 || MemData !== 0) begin
            fails++;
            $display("FAIL reset_state: req=%b we=%b stall=%b aerr=%b berr=%b addr=%h wdata=%h ir=%h mdr=%h, required all zero",
                     mem_req, mem_we, Stall, AddrErr, BusErr, mem_addr, mem_wdata, Instruction, MemData);
        end
    endtask

    task automatic test_fetch();
        run_access(1, 0, 0, 1, 32'h10, 32'h0, 32'h0, 3, 32'h8C430004,
                   st, a_s, we_s, wd_s, rq_s, stab, rq_d, rq_a);
        tests_run++;
        if (st !== 4) begin fails++; $display("FAIL fetch_stall: got %0d cycles, required 4", st); end
        tests_run++;
        if (a_s !== 32'h10 || rq_s !== 1'b1 || we_s !== 1'b0 || !stab) begin
            fails++; $display("FAIL fetch_bus: addr=%h req=%b we=%b stable=%0d, required 00000010 1 0 1", a_s, rq_s, we_s, stab);
        end
        tests_run++;
        if (Instruction !== 32'h8C430004 || OpCode !== 6'h23 || Funct !== 6'h04) begin
            fails++; $display("FAIL fetch_ir: ir=%h op=%h fn=%h, required 8c430004 23 04", Instruction, OpCode, Funct);
        end
        tests_run++;
        if (MemData !== 32'h0 || rq_d !== 1'b0 || rq_a !== 1'b0) begin
            fails++; $display("FAIL fetch_mdr_done: mdr=%h req_done=%b req_after=%b, required 0 0 0", MemData, rq_d, rq_a);
        end
    endtask

    task automatic test_load();
        run_access(1, 0, 1, 0, 32'h10, 32'h104, 32'h0, 1, 32'hDEADBEEF,
                   st, a_s, we_s, wd_s, rq_s, stab, rq_d, rq_a);
        tests_run++;
        if (st !== 2) begin fails++; $display("FAIL load_stall: got %0d cycles, required 2", st); end
        tests_run++;
        if (MemData !== 32'hDEADBEEF || Instruction !== 32'h8C430004 || a_s !== 32'h104) begin
            fails++; $display("FAIL load_data: mdr=%h ir=%h addr=%h, required deadbeef 8c430004 00000104", MemData, Instruction, a_s);
        end
    endtask

    task automatic test_store();
        run_access(0, 1, 1, 0, 32'h10, 32'h200, 32'h12345678, 2, 32'h55555555,
                   st, a_s, we_s, wd_s, rq_s, stab, rq_d, rq_a);
        tests_run++;
        if (we_s !== 1'b1 || wd_s !== 32'h12345678 || a_s !== 32'h200 || !stab || st !== 3) begin
            fails++; $display("FAIL store_bus: we=%b wdata=%h addr=%h stable=%0d stalls=%0d, required 1 12345678 00000200 1 3",
                              we_s, wd_s, a_s, stab, st);
        end
        tests_run++;
        if (MemData !== 32'hDEADBEEF || Instruction !== 32'h8C430004 || mem_we !== 1'b0) begin
            fails++; $display("FAIL store_regs: mdr=%h ir=%h we_after=%b, required deadbeef 8c430004 0", MemData, Instruction, mem_we);
        end
    endtask

    task automatic test_misaligned();
        tests_run++;
        if (AddrErr !== 1'b0) begin fails++; $display("FAIL misaligned_pre: aerr=%b, required 0", AddrErr); end
        run_access(1, 0, 1, 0, 32'h10, 32'h102, 32'h0, 1, 32'h11111111,
                   st, a_s, we_s, wd_s, rq_s, stab, rq_d, rq_a);
        tests_run++;
        if (AddrErr !== 1'b1 || st !== 0 || rq_d !== 1'b0 || rq_a !== 1'b0 || MemData !== 32'hDEADBEEF) begin
            fails++; $display("FAIL misaligned: aerr=%b stalls=%0d req=%b/%b mdr=%h, required 1 0 0/0 deadbeef",
                              AddrErr, st, rq_d, rq_a, MemData);
        end
    endtask

    task automatic test_timeout();
        run_access(1, 0, 0, 1, 32'h20, 32'h0, 32'h0, 0, 32'h0,
                   st, a_s, we_s, wd_s, rq_s, stab, rq_d, rq_a);
        tests_run++;
        if (st !== 65) begin fails++; $display("FAIL timeout_stall: got %0d cycles, required 65", st); end
        tests_run++;
        if (BusErr !== 1'b1 || rq_d !== 1'b0 || rq_a !== 1'b0 || Instruction !== 32'h8C430004) begin
            fails++; $display("FAIL timeout_state: berr=%b req=%b/%b ir=%h, required 1 0/0 8c430004", BusErr, rq_d, rq_a, Instruction);
        end
    endtask

    task automatic test_reset_mid_wait();
        MemRead = 1; IorD = 0; IRWrite = 1; PC = 32'h40; mem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL midwait_pre: req=%b, required 1", mem_req); end
        reset = 1'b1;
        MemRead = 0; IRWrite = 0;
        #1;
        tests_run++;
        if (mem_req !== 1'b0 || Stall !== 1'b0 || Instruction !== 0 || MemData !== 0 ||
            AddrErr !== 1'b0 || BusErr !== 1'b0) begin
            fails++; $display("FAIL midwait_reset: req=%b stall=%b ir=%h mdr=%h aerr=%b berr=%b, required all zero",
                              mem_req, Stall, Instruction, MemData, AddrErr, BusErr);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_access(1, 0, 0, 1, 32'h44, 32'h0, 32'h0, 2, 32'h03E00008,
                   st, a_s, we_s, wd_s, rq_s, stab, rq_d, rq_a);
        tests_run++;
        if (Instruction !== 32'h03E00008 || OpCode !== 6'h00 || Funct !== 6'h08 || st !== 3 || a_s !== 32'h44) begin
            fails++; $display("FAIL refetch: ir=%h op=%h fn=%h stalls=%0d addr=%h, required 03e00008 00 08 3 00000044",
                              Instruction, OpCode, Funct, st, a_s);
        end
    endtask

    task automatic test_conflict();
        apply_reset();
        run_access(1, 1, 1, 0, 32'h10, 32'h300, 32'h0, 1, 32'h22222222,
                   st, a_s, we_s, wd_s, rq_s, stab, rq_d, rq_a);
        tests_run++;
        if (AddrErr !== 1'b1 || st !== 0 || rq_a !== 1'b0 || MemData !== 0 || BusErr !== 1'b0) begin
            fails++; $display("FAIL conflict: aerr=%b stalls=%0d req=%b mdr=%h berr=%b, required 1 0 0 0 0",
                              AddrErr, st, rq_a, MemData, BusErr);
        end
    endtask

    initial begin
        reset = 1'b1;
        MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
        PC = 0; ALUOut = 0; WriteData = 0; mem_rdata = 0; mem_ack = 0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_conflict();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

`default_nettype wire
